// File: rtl/scan_chain_responder.sv
// ----------------------------------------------------------------------------
// scan_chain_responder
//
// DUT-side end of a parallel scan interface. Holds NUM_CHAINS shift chains of
// CHAIN_LEN flops each, shifts serial stimulus in on scan_in, presents each
// chain's last flop on scan_out, performs single-cycle parallel capture from
// core logic and compacts the unloaded response into a MISR signature.
//
// Ports:
//   clock         single clock for all state
//   reset         asynchronous, active-low reset
//   scan_en       shift one bit per chain per cycle
//   capture_en    parallel capture request (rising-edge qualified)
//   capture_data  core response, chain c bit k = capture_data[c*CHAIN_LEN+k]
//   scan_in       serial input, bit c feeds chain c
//   misr_clear    synchronous clear of the signature
//   scan_out      bit c = chain c flop [CHAIN_LEN-1]
//   chain_q       parallel chain contents, same packing as capture_data
//   shift_count   shifts since SHIFT entry, modulo CHAIN_LEN
//   load_done     one-cycle pulse after each complete CHAIN_LEN-shift load
//   misr_sig      current signature
//   state         IDLE=0, SHIFT=1, CAPTURE=2
//   conflict_err  sticky flag: scan_en and capture_en seen together
// ----------------------------------------------------------------------------
module scan_chain_responder #(
  parameter int                NUM_CHAINS = 4,
  parameter int                CHAIN_LEN  = 32,
  parameter int                CNT_W      = 6,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'h1021
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            scan_en,
  input  logic                            capture_en,
  input  logic [NUM_CHAINS*CHAIN_LEN-1:0] capture_data,
  input  logic [NUM_CHAINS-1:0]           scan_in,
  input  logic                            misr_clear,
  output logic [NUM_CHAINS-1:0]           scan_out,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] chain_q,
  output logic [CNT_W-1:0]                shift_count,
  output logic                            load_done,
  output logic [MISR_W-1:0]               misr_sig,
  output logic [1:0]                      state,
  output logic                            conflict_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  // One MISR step: shift, polynomial feedback from the MSB, fold in the data.
  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0]     sig,
    input logic [NUM_CHAINS-1:0] din
  );
    logic [MISR_W-1:0] fb;
    fb = sig[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}};
    return {sig[MISR_W-2:0], 1'b0} ^ fb ^ MISR_W'(din);
  endfunction

  state_e                            state_q, state_d;
  logic [NUM_CHAINS*CHAIN_LEN-1:0]   chains_q, chains_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              load_done_q, load_done_d;
  logic [MISR_W-1:0]                 misr_q, misr_d;
  logic                              conflict_q, conflict_d;
  logic                              cap_prev_q, cap_prev_d;

  logic                              shift_s;
  logic                              capture_s;
  logic                              entry_s;
  logic                              cap_rise_s;
  logic [NUM_CHAINS-1:0]             msb_s;

  // A held capture_en only counts once: capture needs a low-to-high edge.
  assign cap_rise_s = capture_en & ~cap_prev_q;

  // Gather the MSB of every chain; these are the serial outputs.
  always_comb begin
    msb_s = {NUM_CHAINS{1'b0}};
    for (int c = 0; c < NUM_CHAINS; c++) begin
      msb_s[c] = chains_q[c*CHAIN_LEN + CHAIN_LEN - 1];
    end
  end

  // Next-state logic; scan_en always wins over capture_en.
  always_comb begin
    state_d   = state_q;
    shift_s   = 1'b0;
    capture_s = 1'b0;
    entry_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = SHIFT;
          shift_s = 1'b1;
          entry_s = 1'b1;
        end else if (cap_rise_s) begin
          state_d   = CAPTURE;
          capture_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (scan_en) begin
          state_d = SHIFT;
          shift_s = 1'b1;
        end else if (cap_rise_s) begin
          state_d   = CAPTURE;
          capture_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (scan_en) begin
          state_d = SHIFT;
          shift_s = 1'b1;
          entry_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: chains, shift counter, load pulse, signature, sticky error.
  always_comb begin
    chains_d    = chains_q;
    cnt_d       = cnt_q;
    load_done_d = 1'b0;
    misr_d      = misr_q;
    conflict_d  = conflict_q | (scan_en & capture_en);
    cap_prev_d  = capture_en;

    if (shift_s) begin
      for (int c = 0; c < NUM_CHAINS; c++) begin
        chains_d[c*CHAIN_LEN +: CHAIN_LEN] =
          {chains_q[c*CHAIN_LEN +: CHAIN_LEN-1], scan_in[c]};
      end
      // The counter restarts at 1 on every SHIFT entry; CHAIN_LEN >= 2 so
      // that first shift can never complete a load.
      if (entry_s) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q == LAST_CNT) begin
        cnt_d       = {CNT_W{1'b0}};
        load_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (capture_s) begin
      chains_d = capture_data;
    end else begin
      chains_d = chains_q;
    end

    // The signature absorbs the values on scan_out before the shift edge.
    if (misr_clear) begin
      misr_d = {MISR_W{1'b0}};
    end else if (shift_s) begin
      misr_d = misr_step(misr_q, msb_s);
    end else begin
      misr_d = misr_q;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      chains_q    <= {(NUM_CHAINS*CHAIN_LEN){1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      load_done_q <= 1'b0;
      misr_q      <= {MISR_W{1'b0}};
      conflict_q  <= 1'b0;
      cap_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      chains_q    <= chains_d;
      cnt_q       <= cnt_d;
      load_done_q <= load_done_d;
      misr_q      <= misr_d;
      conflict_q  <= conflict_d;
      cap_prev_q  <= cap_prev_d;
    end
  end

  assign scan_out     = msb_s;
  assign chain_q      = chains_q;
  assign shift_count  = cnt_q;
  assign load_done    = load_done_q;
  assign misr_sig     = misr_q;
  assign state        = state_q;
  assign conflict_err = conflict_q;

endmodule

// File: tb/tb_scan_chain_responder.sv
// ----------------------------------------------------------------------------
// Testbench for scan_chain_responder (NUM_CHAINS=4, CHAIN_LEN=4).
// A driver applies directed and random stimulus on the falling clock edge,
// advances a behavioural model and queues the expected outputs; a monitor
// samples the DUT shortly after each rising clock edge (and after each reset
// assertion) and compares against the head of the queue.
// ----------------------------------------------------------------------------
module tb_scan_chain_responder;

  localparam int NC = 4;
  localparam int CL = 4;
  localparam int CW = 3;
  localparam int MW = 16;
  localparam logic [MW-1:0] POLY = 16'h1021;

  logic             clock;
  logic             reset;
  logic             scan_en;
  logic             capture_en;
  logic [NC*CL-1:0] capture_data;
  logic [NC-1:0]    scan_in;
  logic             misr_clear;
  logic [NC-1:0]    scan_out;
  logic [NC*CL-1:0] chain_q;
  logic [CW-1:0]    shift_count;
  logic             load_done;
  logic [MW-1:0]    misr_sig;
  logic [1:0]       state;
  logic             conflict_err;

  scan_chain_responder #(
    .NUM_CHAINS(NC), .CHAIN_LEN(CL), .CNT_W(CW), .MISR_W(MW), .MISR_POLY(POLY)
  ) dut (
    .clock(clock), .reset(reset), .scan_en(scan_en), .capture_en(capture_en),
    .capture_data(capture_data), .scan_in(scan_in), .misr_clear(misr_clear),
    .scan_out(scan_out), .chain_q(chain_q), .shift_count(shift_count),
    .load_done(load_done), .misr_sig(misr_sig), .state(state),
    .conflict_err(conflict_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NC-1:0]    so;
    logic [NC*CL-1:0] cq;
    logic [CW-1:0]    cnt;
    logic             ld;
    logic [MW-1:0]    sig;
    logic [1:0]       st;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // ---------------- behavioural reference model ----------------
  logic [CL-1:0] m_chain[NC];
  int            m_mode;      // 0 idle, 1 shifting, 2 capture cycle
  int            m_shifts;    // shifts since last entry into shifting
  logic          m_ld;
  logic [MW-1:0] m_sig;
  logic          m_err;
  logic          m_ce_prev;

  function automatic logic [NC-1:0] m_msbs();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = m_chain[c][CL-1];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) m_chain[c] = '0;
    m_mode = 0; m_shifts = 0; m_ld = 1'b0; m_sig = '0;
    m_err = 1'b0; m_ce_prev = 1'b0;
  endtask

  task automatic model_step(input bit se, input bit ce, input logic [NC-1:0] sin,
                            input logic [NC*CL-1:0] cd, input bit clr);
    bit            rise;
    bit            do_shift;
    bit            do_cap;
    int            next_mode;
    logic [NC-1:0] so_before;
    logic [MW-1:0] s;
    rise      = ce && !m_ce_prev;
    so_before = m_msbs();
    do_shift  = se;
    do_cap    = !se && rise && (m_mode != 2);
    if (se && ce) m_err = 1'b1;
    if (do_shift) begin
      if (m_mode != 1) m_shifts = 1;
      else             m_shifts = m_shifts + 1;
      next_mode = 1;
      for (int c = 0; c < NC; c++) m_chain[c] = {m_chain[c][CL-2:0], sin[c]};
      m_ld = (m_shifts % CL) == 0;
    end else begin
      next_mode = do_cap ? 2 : 0;
      m_ld = 1'b0;
      if (do_cap) for (int c = 0; c < NC; c++) m_chain[c] = cd[c*CL +: CL];
    end
    if (clr) m_sig = '0;
    else if (do_shift) begin
      s = m_sig << 1;
      if (m_sig[MW-1]) s = s ^ POLY;
      m_sig = s ^ MW'(so_before);
    end
    m_mode    = next_mode;
    m_ce_prev = ce;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.so  = m_msbs();
    for (int c = 0; c < NC; c++) e.cq[c*CL +: CL] = m_chain[c];
    e.cnt = CW'(m_shifts % CL);
    e.ld  = m_ld;
    e.sig = m_sig;
    e.st  = 2'(m_mode);
    e.err = m_err;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit se, input bit ce, input logic [NC-1:0] sin,
                      input logic [NC*CL-1:0] cd, input bit clr);
    scan_en = se; capture_en = ce; scan_in = sin;
    capture_data = cd; misr_clear = clr;
    model_step(se, ce, sin, cd, clr);
    exp_q.push_back(model_out());
    @(negedge clock);
  endtask

  // Assert reset mid-cycle, expect all-zero outputs before the next edge,
  // hold it across one rising edge, release on the following falling edge.
  task automatic async_reset();
    #2;
    scan_en = 1'b0; capture_en = 1'b0; scan_in = '0; misr_clear = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    exp_q.push_back(model_out());
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scan_out",     32'(scan_out),     32'(e.so));
        chk("chain_q",      32'(chain_q),      32'(e.cq));
        chk("shift_count",  32'(shift_count),  32'(e.cnt));
        chk("load_done",    32'(load_done),    32'(e.ld));
        chk("misr_sig",     32'(misr_sig),     32'(e.sig));
        chk("state",        32'(state),        32'(e.st));
        chk("conflict_err", 32'(conflict_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; scan_en = 1'b0; capture_en = 1'b0;
    capture_data = '0; scan_in = '0; misr_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Quiet after reset release.
    repeat (5) step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);

    // One full load of 4'b1010; chains 1 and 3 fill with ones.
    repeat (4) step(1'b1, 1'b0, 4'b1010, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b1);

    // Capture then unload into the signature.
    step(1'b0, 1'b1, 4'h0, 16'hA5C3, 1'b0);
    repeat (4) step(1'b1, 1'b0, 4'h0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);

    // Held capture_en captures only once.
    step(1'b0, 1'b1, 4'h0, 16'h1357, 1'b0);
    step(1'b0, 1'b1, 4'h0, 16'h2468, 1'b0);
    step(1'b0, 1'b1, 4'h0, 16'h9BDF, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);

    // Conflict: shift wins, capture dropped, flag sticks; later capture works.
    step(1'b1, 1'b0, 4'b0110, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 4'b0101, 16'hFFFF, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 4'h0, 16'h1234, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);

    // Pause after 2 shifts, resume: count restarts, load_done after 4 more.
    repeat (2) step(1'b1, 1'b0, 4'b1100, 16'h0000, 1'b0);
    repeat (3) step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);
    repeat (5) step(1'b1, 1'b0, 4'b0011, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);

    // Reset in the middle of a load.
    repeat (3) step(1'b1, 1'b0, 4'b1111, 16'h0000, 1'b0);
    async_reset();
    step(1'b1, 1'b0, 4'b1001, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 4'b0110, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);

    // Randomized traffic with long shift bursts.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           NC'($urandom), (NC*CL)'($urandom), ($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0);

    @(posedge clock);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
